reg_dump: RTL and testbench
===========================

Name: reg_dump

Overview:
- Debug read-out engine for the picoMIPS 8-bit general-purpose register file. It is the reader side of that file.
- On a start pulse it walks register addresses 0..NREGS-1 through one asynchronous read port. Each value is captured and presented to a downstream consumer over a valid/ready byte handshake.
- While a dump is in progress it asserts freeze. The core uses freeze to suppress register writes, so the dump is a consistent snapshot.

Parameters:
- n, 8, data width of a register and of dout.
- NREGS, 5, number of registers dumped (addresses 0..NREGS-1).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a dump; sampled only in IDLE.
- raddr  output  5  read address driven to the register file read port.
- rdata  input  n  combinational read data returned for raddr.
- dout  output  n  captured register value.
- idx  output  5  register address that dout came from.
- valid  output  1  dout/idx are valid.
- ready  input  1  consumer accepts the beat when valid&&ready at a rising edge.
- busy  output  1  dump in progress.
- freeze  output  1  equals busy; core gates its register write enable with !freeze.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous, any state, including mid-dump):
  - state=IDLE, raddr=0, dout=0, idx=0.
  - valid=0, busy=0, freeze=0, done=0.
  - Any partial dump is abandoned; no done pulse is issued.
- States:
  - IDLE: if start=1, then state<=READ, raddr<=0, busy<=1. Otherwise hold.
  - READ: dout<=rdata, idx<=raddr, valid<=1, state<=SEND. This is one cycle. rdata is combinational from raddr, so it is stable here.
  - SEND: hold dout/idx/valid stable while ready=0, with no timeout.
    - On valid&&ready with idx<NREGS-1: valid<=0, raddr<=raddr+1, state<=READ.
    - On valid&&ready with idx==NREGS-1: valid<=0, state<=DONE.
  - DONE: done<=1 for exactly one cycle, busy<=0, raddr<=0, state<=IDLE.
- Latency:
  - start sampled at edge E0; busy=1 after E0.
  - First valid=1 after E1.
  - With ready held at 1, each beat takes 2 cycles; the full dump takes 2*NREGS+1 cycles from start to done.
- start while busy (READ/SEND/DONE) is ignored. It is not queued.
- start asserted in the same cycle that DONE returns to IDLE is ignored. A new dump requires start sampled in IDLE.
- freeze is the registered busy bit, high from the edge after start through the DONE cycle inclusive. It is low in the cycle done is visible only if DONE clears busy at the same edge that raises done; the required relation is done=1 and busy=0 in the same cycle.
- raddr never exceeds NREGS-1. No wrap-around occurs; the address returns to 0 only via DONE or reset.
- valid must never deassert without a handshake (except by reset).
- dout and idx must not change while valid=1.
- dout holds the last captured value after the dump, until the next READ.

Test Plan:
- Basic dump: preload regs 0..4 = 00,11,22,33,44; pulse start; ready=1 -> beats (idx,dout) = (0,00),(1,11),(2,22),(3,33),(4,44); done pulse 11 cycles after start; busy/freeze high throughout; busy=0 when done=1.
- Backpressure: ready=0 for 6 cycles on beat 2 -> dout=22 and idx=2 held stable with valid=1 for all 6 cycles; remaining beats in order; no beat lost or duplicated.
- Start ignored: re-pulse start during beat 1 and during the DONE cycle -> exactly 5 beats and one done; module in IDLE afterwards.
- Reset mid-dump: assert reset asynchronously (off-edge) during beat 3 SEND -> valid, busy, freeze, done drop to 0 immediately; raddr=0; a new start gives a full dump from idx 0.
- Freeze snapshot: core attempts a write of FF to reg 3 while freeze=1 (write gated) -> beat 3 dout=33; after done, the write succeeds and a second dump shows FF at idx 3.
- Back-to-back: start pulsed the cycle after done (IDLE) -> second full dump of 5 beats with identical timing.

Source files
------------

// File: rtl/reg_dump.sv
`timescale 1ns/1ps
// reg_dump: snapshot read-out engine for the picoMIPS register file.
// On start it walks addresses 0..NREGS-1 through the asynchronous read port.
// Each captured value is handed downstream on a valid/ready byte handshake.
// freeze is held for the whole dump so the core cannot write mid-snapshot.
module reg_dump #(
    parameter int n     = 8,
    parameter int NREGS = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [4:0]   raddr,
    input  logic [n-1:0] rdata,
    output logic [n-1:0] dout,
    output logic [4:0]   idx,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         freeze,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_t         state_q;
    logic [4:0]     raddr_q;
    logic [4:0]     raddr_d;
    logic [4:0]     idx_q;
    logic [n-1:0]   dout_q;
    logic           valid_q;
    logic           busy_q;
    logic           done_q;
    logic           accept;

    // Beat acceptance and saturating next read address (never passes LAST_IDX)
    always_comb begin
        accept  = 1'b0;
        raddr_d = raddr_q;
        if (valid_q && ready) begin
            accept = 1'b1;
        end else begin
            accept = 1'b0;
        end
        if (raddr_q < LAST_IDX) begin
            raddr_d = raddr_q + 5'd1;
        end else begin
            raddr_d = raddr_q;
        end
    end

    // Dump sequencer: IDLE -> (READ -> SEND)*NREGS -> DONE -> IDLE, all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            raddr_q <= 5'd0;
            idx_q   <= 5'd0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_READ;
                        raddr_q <= 5'd0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    // rdata is combinational from raddr, which has been stable a full cycle
                    done_q  <= 1'b0;
                    dout_q  <= rdata;
                    idx_q   <= raddr_q;
                    valid_q <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (idx_q < LAST_IDX) begin
                            raddr_q <= raddr_d;
                            state_q <= S_READ;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        // backpressure: hold the beat indefinitely
                        state_q <= S_SEND;
                    end
                end
                S_DONE: begin
                    // busy drops at the same edge done rises
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    raddr_q <= 5'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    raddr_q <= 5'd0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign raddr  = raddr_q;
    assign dout   = dout_q;
    assign idx    = idx_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign freeze = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_reg_dump.sv
`timescale 1ns/1ps
// Directed testbench for reg_dump with a small write-gated register file model.
module tb_reg_dump;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ready;
    logic [4:0] raddr;
    logic [4:0] idx;
    logic [7:0] rdata;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
    logic       freeze;
    logic       done;

    logic       we;
    logic [4:0] wa;
    logic [7:0] wd;
    logic [7:0] regs [0:31];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [4:0] beat_i [$];
    logic [7:0] beat_d [$];
    int done_cnt, done_lat, busy_err, stab_err, stall_seen;

    logic [7:0] exp_d [0:4];

    always #5 clk = ~clk;

    reg_dump #(.n(8), .NREGS(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .raddr  (raddr),
        .rdata  (rdata),
        .dout   (dout),
        .idx    (idx),
        .valid  (valid),
        .ready  (ready),
        .busy   (busy),
        .freeze (freeze),
        .done   (done)
    );

    // Register file model: async read, write gated by freeze
    assign rdata = regs[raddr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we && !freeze) regs[wa] <= wd;
    end

    // Drive one dump and record beats, done timing, busy/freeze and stall behaviour
    task automatic run_dump(input int stall_idx, input int stall_len, input bit restart,
                            input bit try_wr, input int tail);
        int s0, stalled, post;
        logic [7:0] hd;
        logic [4:0] hi;
        bit fin, last_acc, r1_done;
        beat_i.delete();
        beat_d.delete();
        done_cnt = 0; done_lat = -1; busy_err = 0; stab_err = 0; stall_seen = 0;
        stalled = 0; post = 0; fin = 1'b0; last_acc = 1'b0; r1_done = 1'b0;
        hd = 8'h00; hi = 5'd0;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        s0 = cyc + 1;
        for (int k = 0; k < 120 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            we    = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = cyc - s0;
                if (busy !== 1'b0 || freeze !== 1'b0) busy_err++;
            end else if (done_cnt == 0 && (busy !== 1'b1 || freeze !== 1'b1)) begin
                busy_err++;
            end
            if (try_wr && busy) begin
                we = 1'b1; wa = 5'd3; wd = 8'hFF;
            end
            if (restart && valid && idx == 5'd1 && !r1_done) begin
                start = 1'b1; r1_done = 1'b1;
            end
            if (restart && last_acc && busy && !valid) start = 1'b1;
            last_acc = 1'b0;
            if (valid && idx == 5'(stall_idx) && stalled < stall_len) begin
                if (stalled > 0 && (dout !== hd || idx !== hi)) stab_err++;
                hd = dout; hi = idx;
                stalled++; stall_seen++;
                ready = 1'b0;
            end else begin
                ready = 1'b1;
                if (valid) begin
                    beat_i.push_back(idx);
                    beat_d.push_back(dout);
                    if (idx == 5'd4) last_acc = 1'b1;
                end
            end
            if (done_cnt > 0) begin
                if (post >= tail) fin = 1'b1;
                post++;
            end
        end
        start = 1'b0;
        we    = 1'b0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ready = 1'b0; we = 1'b0; wa = 5'd0; wd = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid, busy, freeze, done} !== 4'b0000 || raddr !== 5'd0 || idx !== 5'd0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got v/b/f/d=%b%b%b%b raddr=%0d idx=%0d dout=%h, want 0000 0 0 00",
                     valid, busy, freeze, done, raddr, idx, dout);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({valid, busy, freeze, done} !== 4'b0000 || raddr !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got v/b/f/d=%b%b%b%b raddr=%0d, want 0000 0",
                     valid, busy, freeze, done, raddr);
        end
        // preload the register file through its write port
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 5'(i); wd = exp_d[i];
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_basic();
        run_dump(-1, 0, 1'b0, 1'b0, 4);
        n_checks++;
        if (beat_i.size() != 5) begin
            n_fail++; $display("FAIL basic_count: got %0d beats, want 5", beat_i.size());
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= beat_i.size() || beat_i[k] !== 5'(k) || beat_d[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got idx=%0d dout=%h, want idx=%0d dout=%h",
                         k, beat_i[k], beat_d[k], k, exp_d[k]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_lat != 11) begin
            n_fail++; $display("FAIL basic_done: got count=%0d latency=%0d, want 1 11", done_cnt, done_lat);
        end
        n_checks++;
        if (busy_err != 0) begin
            n_fail++; $display("FAIL basic_busy_freeze: got %0d violations, want 0", busy_err);
        end
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || raddr !== 5'd0 || dout !== 8'h44) begin
            n_fail++;
            $display("FAIL basic_after: got busy=%b valid=%b raddr=%0d dout=%h, want 0 0 0 44",
                     busy, valid, raddr, dout);
        end
    endtask

    task automatic test_backpressure();
        run_dump(2, 6, 1'b0, 1'b0, 4);
        n_checks++;
        if (stall_seen != 6 || stab_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got stalled=%0d unstable=%0d, want 6 0", stall_seen, stab_err);
        end
        n_checks++;
        if (beat_i.size() != 5) begin
            n_fail++; $display("FAIL bp_count: got %0d beats, want 5", beat_i.size());
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= beat_i.size() || beat_i[k] !== 5'(k) || beat_d[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got idx=%0d dout=%h, want idx=%0d dout=%h",
                         k, beat_i[k], beat_d[k], k, exp_d[k]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_lat != 17) begin
            n_fail++; $display("FAIL bp_done: got count=%0d latency=%0d, want 1 17", done_cnt, done_lat);
        end
    endtask

    task automatic test_start_ignored();
        run_dump(-1, 0, 1'b1, 1'b0, 4);
        n_checks++;
        if (beat_i.size() != 5 || done_cnt != 1 || done_lat != 11) begin
            n_fail++;
            $display("FAIL restart_ignored: got beats=%0d dones=%0d latency=%0d, want 5 1 11",
                     beat_i.size(), done_cnt, done_lat);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= beat_i.size() || beat_i[k] !== 5'(k) || beat_d[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL restart_beat%0d: got idx=%0d dout=%h, want idx=%0d dout=%h",
                         k, beat_i[k], beat_d[k], k, exp_d[k]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL restart_idle: got busy=%b valid=%b, want 0 0", busy, valid);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        @(negedge clk);
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (valid && idx == 5'd3) begin
                found = 1'b1;
                ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rst_mid_reach: got beat 3 not seen, want beat 3 in SEND");
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({valid, busy, freeze, done} !== 4'b0000 || raddr !== 5'd0 || idx !== 5'd0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got v/b/f/d=%b%b%b%b raddr=%0d idx=%0d dout=%h, want 0000 0 0 00",
                     valid, busy, freeze, done, raddr, idx, dout);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_nodone: got done=%b busy=%b, want 0 0", done, busy);
        end
        reset = 1'b0;
        ready = 1'b1;
        run_dump(-1, 0, 1'b0, 1'b0, 4);
        n_checks++;
        if (beat_i.size() != 5 || done_cnt != 1 || done_lat != 11) begin
            n_fail++;
            $display("FAIL rst_mid_redump: got beats=%0d dones=%0d latency=%0d, want 5 1 11",
                     beat_i.size(), done_cnt, done_lat);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= beat_i.size() || beat_i[k] !== 5'(k) || beat_d[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL rst_mid_beat%0d: got idx=%0d dout=%h, want idx=%0d dout=%h",
                         k, beat_i[k], beat_d[k], k, exp_d[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_dump(-1, 0, 1'b0, 1'b0, 0);
        n_checks++;
        if (beat_i.size() != 5 || done_cnt != 1 || done_lat != 11) begin
            n_fail++;
            $display("FAIL b2b_first: got beats=%0d dones=%0d latency=%0d, want 5 1 11",
                     beat_i.size(), done_cnt, done_lat);
        end
        run_dump(-1, 0, 1'b0, 1'b0, 4);
        n_checks++;
        if (beat_i.size() != 5 || done_cnt != 1 || done_lat != 11 || busy_err != 0) begin
            n_fail++;
            $display("FAIL b2b_second: got beats=%0d dones=%0d latency=%0d busyerr=%0d, want 5 1 11 0",
                     beat_i.size(), done_cnt, done_lat, busy_err);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= beat_i.size() || beat_i[k] !== 5'(k) || beat_d[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got idx=%0d dout=%h, want idx=%0d dout=%h",
                         k, beat_i[k], beat_d[k], k, exp_d[k]);
            end
        end
    endtask

    task automatic test_freeze();
        run_dump(-1, 0, 1'b0, 1'b1, 4);
        n_checks++;
        if (beat_d.size() != 5 || beat_d[3] !== 8'h33) begin
            n_fail++;
            $display("FAIL freeze_snapshot: got beats=%0d dout3=%h, want 5 33", beat_d.size(), beat_d[3]);
        end
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 8'hFF;
        @(negedge clk);
        we = 1'b0;
        run_dump(-1, 0, 1'b0, 1'b0, 4);
        n_checks++;
        if (beat_d.size() != 5 || beat_i[3] !== 5'd3 || beat_d[3] !== 8'hFF || beat_d[4] !== 8'h44) begin
            n_fail++;
            $display("FAIL freeze_after: got beats=%0d idx3=%0d dout3=%h dout4=%h, want 5 3 ff 44",
                     beat_d.size(), beat_i[3], beat_d[3], beat_d[4]);
        end
    endtask

    initial begin
        exp_d[0] = 8'h00; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33; exp_d[4] = 8'h44;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
